// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a synchronous FIFO and its drain stage.
// master: drain side (drives fifo_rd); slave: FIFO side (drives empty/data).
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_data;

  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_data
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit FIFO one byte at a time and sends it as UART 8N1.
// Ports: clk, rst (sync, high), enable, fifo (read port), tx, busy.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, LOAD, START, DATA, STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          rd;
  logic          bit_end;
  logic          go;

  assign bit_end = (cnt == LAST);
  assign go = enable && !fifo.fifo_empty;
  assign fifo.fifo_rd = rd;

  // tx, rd and busy are registered alongside the state so they
  // change on the same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
      rd    <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      rd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state <= REQ;
            rd    <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          state <= LOAD;
        end
        // FIFO output register holds the popped byte now
        LOAD: begin
          shift <= fifo.fifo_data;
          state <= START;
          tx    <= 1'b0;
          cnt   <= '0;
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            cnt   <= '0;
            idx   <= '0;
            tx    <= shift[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              state <= STOP;
              idx   <= '0;
              tx    <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
              tx  <= shift[idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (go) begin
              state <= REQ;
              rd    <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
